// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage controller: PC ownership, reset/interrupt vector loads, IF/ID register.
// Optional saturating performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_stage_ctrl #(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_VEC = '0,
  parameter logic [PC_W-1:0]     IVT_ADDR  = PC_W'(2),
  parameter logic [INSTR_W-1:0]  NOP       = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               int_stall,
  input  logic               int_inject,
  input  logic [INSTR_W-1:0] int_instr,
  input  logic               int_bubble,
  input  logic               int_to_fetch,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               hazard_stall,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic [PC_W-1:0]    ret_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch,
  output logic [15:0]        perf_inject,
  output logic [15:0]        perf_bubble
`endif
);

  typedef enum logic [2:0] {
    RST_HI,
    RST_LO,
    RUN,
    IVT_HI,
    IVT_LO
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]      ifid_pc_q, ifid_pc_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]      ret_pc_q, ret_pc_d;
  logic [INSTR_W-1:0]   vec_hi_q, vec_hi_d;
  logic                 stall_prev_q;
  logic [2*INSTR_W-1:0] vec_full;
  logic                 fetch_ev;
  logic                 inject_ev;
  logic                 bubble_ev;

  assign vec_full = {vec_hi_q, imem_data};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    ret_pc_d     = ret_pc_q;
    vec_hi_d     = vec_hi_q;
    imem_addr    = pc_q;
    fetch_ev     = 1'b0;
    inject_ev    = 1'b0;
    bubble_ev    = 1'b0;

    unique case (state_q)
      RST_HI: begin
        imem_addr    = RESET_VEC;
        vec_hi_d     = imem_data;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        bubble_ev    = 1'b1;
        state_d      = RST_LO;
      end
      RST_LO: begin
        imem_addr    = RESET_VEC + PC_W'(1);
        pc_d         = PC_W'(vec_full);
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        bubble_ev    = 1'b1;
        state_d      = RUN;
      end
      IVT_HI: begin
        imem_addr    = IVT_ADDR;
        vec_hi_d     = imem_data;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        bubble_ev    = 1'b1;
        state_d      = IVT_LO;
      end
      IVT_LO: begin
        imem_addr    = IVT_ADDR + PC_W'(1);
        pc_d         = PC_W'(vec_full);
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        bubble_ev    = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        // ret_pc tracks the stall edge independently of which action wins below
        if (int_stall && !stall_prev_q) begin
          ret_pc_d = pc_q;
        end
        if (int_to_fetch) begin
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          bubble_ev    = 1'b1;
          state_d      = IVT_HI;
        end else if (br_taken) begin
          pc_d         = br_target;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          bubble_ev    = 1'b1;
        end else if (int_inject) begin
          ifid_instr_d = int_bubble ? NOP : int_instr;
          ifid_valid_d = ~int_bubble;
          ifid_pc_d    = pc_q;
          inject_ev    = ~int_bubble;
          bubble_ev    = int_bubble;
        end else if (hazard_stall) begin
          ifid_instr_d = ifid_instr_q;
        end else if (int_stall) begin
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          bubble_ev    = 1'b1;
        end else begin
          ifid_instr_d = imem_data;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_W'(1);
          fetch_ev     = 1'b1;
        end
      end
      default: begin
        state_d = RST_HI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_HI;
      pc_q         <= '0;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ret_pc_q     <= '0;
      vec_hi_q     <= '0;
      stall_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ret_pc_q     <= ret_pc_d;
      vec_hi_q     <= vec_hi_d;
      stall_prev_q <= int_stall;
    end
  end

  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ret_pc     = ret_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_q, perf_inject_q, perf_bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_inject_q <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (fetch_ev && (perf_fetch_q != '1)) begin
        perf_fetch_q <= perf_fetch_q + 16'd1;
      end
      if (inject_ev && (perf_inject_q != '1)) begin
        perf_inject_q <= perf_inject_q + 16'd1;
      end
      if (bubble_ev && (perf_bubble_q != '1)) begin
        perf_bubble_q <= perf_bubble_q + 16'd1;
      end
    end
  end

  assign perf_fetch  = perf_fetch_q;
  assign perf_inject = perf_inject_q;
  assign perf_bubble = perf_bubble_q;
`else
  logic unused_ev;
  assign unused_ev = fetch_ev ^ inject_ev ^ bubble_ev;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: reset-vector load, run, branch, interrupt entry,
// hazard stall, IVT redirect, reset during vector load and PC wrap.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        int_stall, int_inject, int_bubble, int_to_fetch;
  logic [15:0] int_instr;
  logic        br_taken;
  logic [31:0] br_target;
  logic        hazard_stall;
  logic [15:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [31:0] ret_pc;

  logic [15:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:0]];

  fetch_stage_ctrl #(
    .PC_W     (32),
    .INSTR_W  (16),
    .RESET_VEC(32'h0),
    .IVT_ADDR (32'h2),
    .NOP      (16'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .int_stall   (int_stall),
    .int_inject  (int_inject),
    .int_instr   (int_instr),
    .int_bubble  (int_bubble),
    .int_to_fetch(int_to_fetch),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .hazard_stall(hazard_stall),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .ret_pc      (ret_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [15:0] instr);
    check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
    check({tag, ".pc"}, ifid_pc, pc);
    check({tag, ".instr"}, {16'd0, ifid_instr}, {16'd0, instr});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, ".instr"}, {16'd0, ifid_instr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h0000; mem[1] = 16'h0040;
    mem[2] = 16'h0000; mem[3] = 16'h0200;

    rst = 1'b1; int_stall = 1'b0; int_inject = 1'b0; int_bubble = 1'b0;
    int_to_fetch = 1'b0; int_instr = 16'h0; br_taken = 1'b0; br_target = 32'h0;
    hazard_stall = 1'b0;

    // 1: reset and reset-vector load
    step();
    check_bubble("rst");
    check("rst.pc", ifid_pc, 32'h0);
    check("rst.ret_pc", ret_pc, 32'h0);
    check("rst.addr_hi", imem_addr, 32'h0);
    rst = 1'b0;
    step();
    check("vec.addr_lo", imem_addr, 32'h1);
    check_bubble("vec.b1");
    step();
    check_bubble("vec.b2");
    check("vec.pc", imem_addr, 32'h40);

    // 2: straight-line fetch
    for (int k = 0; k < 4; k++) begin
      step();
      check_ifid("run", 32'h40 + 32'(k), 16'h1040 + 16'(k));
    end
    step();
    check_ifid("run44", 32'h44, 16'h1044);

    // 3: branch at PC=0x45
    br_taken = 1'b1; br_target = 32'h80;
    step();
    br_taken = 1'b0;
    check_bubble("br.flush");
    check("br.addr", imem_addr, 32'h80);
    step();
    check_ifid("br.target", 32'h80, 16'h1080);

    // 4: interrupt entry with injection at PC=0x50
    br_taken = 1'b1; br_target = 32'h50;
    step();
    br_taken = 1'b0;
    int_stall = 1'b1; int_inject = 1'b1; int_bubble = 1'b1;
    step();
    check("int.ret_pc", ret_pc, 32'h50);
    check_bubble("int.inj_bub");
    check("int.inj_pc", ifid_pc, 32'h50);
    int_bubble = 1'b0; int_instr = 16'hF480;
    step();
    check_ifid("int.inj1", 32'h50, 16'hF480);
    int_instr = 16'h0000;
    step();
    check_ifid("int.inj2", 32'h50, 16'h0000);
    int_inject = 1'b0;
    step();
    check_bubble("int.stall");
    check("int.pc_held", imem_addr, 32'h50);
    check("int.ret_held", ret_pc, 32'h50);
    int_stall = 1'b0;

    // 6a: hazard stall freezes PC and IF/ID
    br_taken = 1'b1; br_target = 32'h5F;
    step();
    br_taken = 1'b0;
    step();
    check_ifid("hz.pre", 32'h5F, 16'h105F);
    hazard_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_ifid("hz.hold", 32'h5F, 16'h105F);
      check("hz.pc", imem_addr, 32'h60);
    end
    hazard_stall = 1'b0;
    step();
    check_ifid("hz.release", 32'h60, 16'h1060);
    hazard_stall = 1'b1; int_inject = 1'b1; int_instr = 16'hABCD;
    step();
    check_ifid("hz.inject_wins", 32'h61, 16'hABCD);
    int_inject = 1'b0; int_stall = 1'b1;
    step();
    check_ifid("hz.over_stall", 32'h61, 16'hABCD);
    check("hz.ret_pc", ret_pc, 32'h61);
    int_stall = 1'b0; hazard_stall = 1'b0;

    // 5: IVT redirect, simultaneous branch dropped
    int_to_fetch = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    step();
    int_to_fetch = 1'b0; br_taken = 1'b0;
    check_bubble("ivt.b0");
    check("ivt.addr_hi", imem_addr, 32'h2);
    step();
    check_bubble("ivt.b1");
    check("ivt.addr_lo", imem_addr, 32'h3);
    step();
    check_bubble("ivt.b2");
    check("ivt.pc", imem_addr, 32'h200);
    step();
    check_ifid("ivt.first", 32'h200, 16'h1200);

    // 6b: reset during IVT_LO
    int_to_fetch = 1'b1;
    step();
    int_to_fetch = 1'b0;
    step();
    check("ivt2.addr_lo", imem_addr, 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bubble("rst2");
    check("rst2.pc", ifid_pc, 32'h0);
    check("rst2.ret_pc", ret_pc, 32'h0);
    check("rst2.addr", imem_addr, 32'h0);
    step();
    step();
    step();
    check_ifid("rst2.first", 32'h40, 16'h1040);

    // PC wrap at 2^32
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 1'b0;
    step();
    check_ifid("wrap.top", 32'hFFFF_FFFF, 16'h13FF);
    check("wrap.addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
